sample_loader: RTL and testbench

SAMPLE_LOADER -- requirements
Module: sample_loader

---
 rtl/sample_loader.sv | 129 ++++++++++++
 tb/tb_sample_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_loader.sv
// Sample loader: streams a frame of samples into a small buffer window
// [first_idx..last_idx], then hands the frame to the MAC with a one-cycle start pulse.
module sample_loader #(
  parameter int N     = 18,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [5:0]   first_idx,
  input  logic [5:0]   last_idx,
  output logic         stf,
  input  logic         eof,
  input  logic [5:0]   i,
  output logic [N-1:0] x,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [5:0]   r_wptr;
  logic [5:0]   r_last_q;
  logic         r_stf;
  logic         r_err;
  logic         r_busy;
  logic         w_stf_next;
  logic         w_err_next;
  logic         w_busy_next;
  logic         w_range_ok;
  logic         w_xfer;
  logic         w_last_beat;
  logic [5:0]   w_waddr;
  logic [N-1:0] r_mem [DEPTH];

  assign w_range_ok  = (first_idx <= last_idx);
  assign w_xfer      = din_valid & din_ready;
  assign w_last_beat = (r_wptr == r_last_q);
  // The first sample of a frame lands at first_idx directly; later ones follow wptr.
  assign w_waddr     = (r_state == S_IDLE) ? first_idx : r_wptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_stf   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_stf   <= w_stf_next;
      r_err   <= w_err_next;
      r_busy  <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_state_next = (first_idx == last_idx) ? S_START : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_xfer && w_last_beat) begin
          w_state_next = S_START;
        end
      end
      S_START: w_state_next = S_WAIT;
      S_WAIT: begin
        if (eof) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    din_ready   = 1'b0;
    w_err_next  = 1'b0;
    w_stf_next  = (w_state_next == S_START);
    w_busy_next = (w_state_next != S_IDLE);
    case (r_state)
      S_IDLE: begin
        din_ready  = w_range_ok;
        w_err_next = din_valid & ~w_range_ok;
      end
      S_LOAD:  din_ready = 1'b1;
      default: din_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= 6'd0;
      r_last_q <= 6'd0;
    end else if (r_state == S_IDLE && w_xfer) begin
      r_last_q <= last_idx;
      r_wptr   <= (first_idx == last_idx) ? first_idx : first_idx + 6'd1;
    end else if (r_state == S_LOAD && w_xfer && !w_last_beat) begin
      // Holding at last_q keeps a frame ending at 63 from wrapping wptr to 0.
      r_wptr <= r_wptr + 6'd1;
    end
  end

  // Buffer contents survive reset; writes are simply suppressed while it is held.
  always_ff @(posedge clk) begin
    if (w_xfer && rst) begin
      r_mem[w_waddr] <= din;
    end
  end

  assign x    = r_mem[i];
  assign stf  = r_stf;
  assign err  = r_err;
  assign busy = r_busy;

endmodule

// File: tb/tb_sample_loader.sv
// Randomized bench for sample_loader: frames are driven with random valid gaps,
// data and index noise, and compared against a frame-level buffer model.
module tb_sample_loader;

  logic        clk;
  logic        rst;
  logic [17:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [5:0]  first_idx;
  logic [5:0]  last_idx;
  logic        stf;
  logic        eof;
  logic [5:0]  i;
  logic [17:0] x;
  logic        busy;
  logic        err;

  logic [17:0] ref_mem [64];
  bit          ref_wr  [64];
  int          n_checks;
  int          n_fail;

  sample_loader #(.N(18), .DEPTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .stf       (stf),
    .eof       (eof),
    .i         (i),
    .x         (x),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // vmode: 0 valid always, 1 alternating, 2 random ~70%.
  // dmode: 0 random data, 1 18'h100+k, 2 all ones.
  task automatic run_frame(input logic [5:0] f, input logic [5:0] l, input int vmode,
                           input int dmode, input int abort_at, input bit eof_in_start,
                           input int wait_cycles);
    int          len;
    int          k;
    int          cyc;
    int          a;
    logic        v;
    logic [17:0] d;
    len = int'(l) - int'(f) + 1;
    first_idx = f;
    last_idx  = l;
    k   = 0;
    cyc = 0;
    while (k < len) begin
      @(negedge clk);
      if (k == abort_at) begin
        rst = 1'b0;
        din_valid = 1'b0;
        #1;
        check_eq("abort_stf", stf, 1'b0);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_err", err, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("abort_stf_hold", stf, 1'b0);
        i = f;
        #1;
        check_eq("keep_after_rst", x, ref_mem[f]);
        #1 rst = 1'b1;
        $display("frame %0d..%0d aborted by reset after %0d samples", f, l, k);
        return;
      end
      if (cyc > 400) begin
        check_eq("frame_timeout", k, len);
        return;
      end
      check_eq("load_busy", busy, (k > 0));
      check_eq("load_stf", stf, 1'b0);
      check_eq("load_err", err, 1'b0);
      check_eq("load_ready", din_ready, (k > 0) ? 1'b1 : (f <= l));
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(99) < 70);
      endcase
      case (dmode)
        1:       d = 18'h00100 + 18'(k);
        2:       d = 18'h3FFFF;
        default: d = 18'($urandom);
      endcase
      cyc++;
      din_valid = v;
      din = d;
      eof = 1'($urandom_range(1));
      if (k > 0) begin
        first_idx = 6'($urandom);
        last_idx  = 6'($urandom);
      end
      a = int'(f) + k;
      i = 6'(a);
      #1;
      if (ref_wr[a]) check_eq("rdw_old", x, ref_mem[a]);
      @(posedge clk);
      #1;
      if (v) begin
        ref_mem[a] = d;
        ref_wr[a]  = 1'b1;
        check_eq("rdw_new", x, d);
        k++;
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
    eof = 1'b0;
    check_eq("start_stf", stf, 1'b1);
    check_eq("start_busy", busy, 1'b1);
    check_eq("start_ready", din_ready, 1'b0);
    check_eq("start_err", err, 1'b0);
    if (dmode == 1 && f == 6'd2) begin
      i = 6'd5;
      #1;
      check_eq("x_i5", x, 18'h00103);
    end
    eof = eof_in_start;
    first_idx = 6'd0;
    last_idx  = 6'd63;
    repeat (wait_cycles) begin
      @(negedge clk);
      eof = 1'b0;
      check_eq("wait_busy", busy, 1'b1);
      check_eq("wait_stf", stf, 1'b0);
      check_eq("wait_ready", din_ready, 1'b0);
      a = $urandom_range(int'(l), int'(f));
      i = 6'(a);
      #1;
      check_eq("wait_x", x, ref_mem[a]);
    end
    @(negedge clk);
    check_eq("wait_busy_pre_eof", busy, 1'b1);
    eof = 1'b1;
    @(negedge clk);
    eof = 1'b0;
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_stf", stf, 1'b0);
    check_eq("idle_ready", din_ready, 1'b1);
    $display("frame %0d..%0d done: %0d samples in %0d cycles", f, l, len, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rf;
    logic [5:0] rl;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    first_idx = 6'd0;
    last_idx  = 6'd0;
    eof       = 1'b0;
    i         = 6'd0;
    for (int a = 0; a < 64; a++) begin
      ref_mem[a] = '0;
      ref_wr[a]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_stf", stf, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", din_ready, 1'b1);
    rst = 1'b1;

    run_frame(6'd2, 6'd28, 0, 1, -1, 1'b0, 10);
    run_frame(6'd2, 6'd28, 1, 0, -1, 1'b0, 3);

    @(negedge clk);
    first_idx = 6'd10;
    last_idx  = 6'd3;
    din_valid = 1'b1;
    din       = 18'($urandom);
    i         = 6'd10;
    #1;
    check_eq("bad_ready", din_ready, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    check_eq("bad_err", err, 1'b1);
    check_eq("bad_busy", busy, 1'b0);
    check_eq("bad_stf", stf, 1'b0);
    check_eq("bad_nowrite", x, ref_mem[10]);
    @(negedge clk);
    check_eq("bad_err_once", err, 1'b0);
    check_eq("bad_stf_after", stf, 1'b0);
    $display("illegal config 10..3 rejected");

    run_frame(6'd63, 6'd63, 0, 2, -1, 1'b1, 2);
    i = 6'd63;
    #1;
    check_eq("x_i63", x, 18'h3FFFF);

    run_frame(6'd2, 6'd28, 0, 0, 5, 1'b0, 0);
    run_frame(6'd2, 6'd28, 2, 0, -1, 1'b0, 2);

    for (int n = 0; n < 8; n++) begin
      rf = 6'($urandom);
      rl = (n == 3) ? rf : 6'($urandom_range(63, int'(rf)));
      run_frame(rf, rl, 2, 0, -1, 1'($urandom_range(1)), $urandom_range(4));
    end

    for (int a = 0; a < 64; a++) begin
      if (ref_wr[a]) begin
        i = 6'(a);
        #1;
        check_eq("sweep_x", x, ref_mem[a]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
